uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
Serial-to-parallel UART receiver. It is the downstream stage of uart_transmitter and consumes its TxD line directly, either in loopback or from an external link. It recovers the 11-bit frame uart_transmitter produces: start(0), D0..D7 LSB first, parity = XOR of D7..D0, stop(1). For each frame it presents one byte, a one-cycle valid pulse, and parity/framing error flags.

Parameters:
OVERSAMPLE, 16, sample ticks per bit period; must match the baud_controller rate.
SYNC_STAGES, 2, flip-flop stages synchronizing RxD into clk.

Ports:
clk  input  1  system clock
rst  input  1  reset (see Behaviour)
RxD  input  1  serial line, idle high, asynchronous to clk
baud_select  input  3  baud rate code, same encoding as the transmitter
Rx_EN  input  1  receiver enable; low forces idle
Rx_DATA  output  8  last received byte
Rx_VALID  output  1  one-clk pulse when a frame completes
Rx_PERROR  output  1  parity mismatch on the last frame
Rx_FERROR  output  1  stop bit sampled low on the last frame

Behaviour:
- One clock, clk; rst is synchronous and active-high.
- Reset values: Rx_DATA=8'h00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0; state=IDLE; all counters 0.
- Reset applies to the baud_controller instance as well.
- RxD passes through a SYNC_STAGES synchronizer, which sets its reset value to 1. All decisions use the synchronized signal rxs.
- Start detect: falling edge only (previous rxs=1, current rxs=0). A line held low never re-arms the receiver.
- Tick = baud_controller sample enable (16x baud). tick_cnt is 4 bits and wraps modulo OVERSAMPLE. bit_cnt is 3 bits.
- States:
  - IDLE: on a falling edge, clear tick_cnt and go to START.
  - START: on the 8th tick (OVERSAMPLE/2, mid start bit), check rxs. If 0, clear tick_cnt and go to DATA. If 1, it is a glitch: return to IDLE with no output change.
  - DATA: on every 16th tick, shift rxs into the MSB of the shift register (LSB-first reception) and increment bit_cnt. After the 8th bit (bit_cnt wraps 7 to 0), go to PARITY.
  - PARITY: on the 16th tick, store par_bit = rxs and go to STOP.
  - STOP: on the 16th tick (mid stop bit), complete the frame and go to IDLE on the same edge.
- Frame completion, registered on the edge after the mid-stop tick:
  - Rx_DATA = shift register; Rx_PERROR = par_bit XOR (^shift); Rx_FERROR = ~rxs; Rx_VALID = 1 for exactly one clk.
  - Rx_VALID pulses even when an error flag is set; the flags qualify the pulse.
  - Latency from the synchronized falling edge to Rx_VALID is 10.5 bit periods plus 1 clk.
- Flag and data hold:
  - Rx_PERROR and Rx_FERROR hold until the next accepted start bit (START to DATA transition), where both clear.
  - Rx_DATA holds until the next completed frame.
- Returning to IDLE at mid-stop gives half a bit period of margin, so back-to-back frames with no idle gap are received.
- Framing error with the line still low: no re-arm until rxs returns high and then falls again.
- Rx_EN=0 (synchronous): state to IDLE, counters cleared, Rx_VALID=0. Rx_DATA and the flags keep their values. A frame in progress is discarded.
- rst asserted mid-frame: full reset values; no Rx_VALID is produced for the interrupted frame.
- Changing baud_select mid-frame is unsupported; the frame result is undefined, but the FSM must still return to IDLE.

Decomposition:
- Shared include uart_defs.vh: RX state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3-bit state), OVERSAMPLE, DATA_BITS=8, IDLE_LEVEL=1.
- Reuse the existing baud_controller for tick generation.
- One new sub-module: uart_rx_sync, containing the SYNC_STAGES synchronizer and falling-edge detector; outputs rxs and fall.

Test Plan:
- Loopback: uart_transmitter TxD to RxD at the same baud_select, send 8'hA5 -> one Rx_VALID pulse, Rx_DATA=8'hA5, PERROR=0, FERROR=0.
- Driven frame 8'h3C with parity bit inverted (1 instead of 0) -> Rx_VALID, Rx_DATA=8'h3C, Rx_PERROR=1, FERROR=0.
- Driven frame 8'h55 with stop bit 0 and the line held low for 3 bit periods -> Rx_FERROR=1. No second Rx_VALID until the line goes high, then a valid frame 8'h12 gives Rx_DATA=8'h12 with both flags 0.
- RxD low for 4 ticks, then high -> no Rx_VALID, FSM back in IDLE; a following frame 8'hC3 is received correctly.
- Back-to-back transmitter frames 8'h00, 8'hFF, 8'h81 with no gap -> exactly three Rx_VALID pulses with matching data and no errors.
- Mid-frame interruption, tested once with Rx_EN driven low and once with rst pulsed for 1 clk, in both cases after bit 4 of frame 8'hF0 -> no Rx_VALID for that frame. After re-enable, frame 8'h81 is received with Rx_DATA=8'h81.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receiver: frame constants, the RX state
// encoding and the baud-rate divisor table.
package uart_receiver_pkg;

  localparam int       DEF_OVERSAMPLE = 16;
  localparam int       DATA_BITS      = 8;
  localparam logic     IDLE_LEVEL     = 1'b1;
  localparam int       BAUD_CNT_W     = 14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Clocks per sample tick (16x baud) for a 50 MHz clk, same code table as
  // the transmitter.
  function automatic logic [BAUD_CNT_W-1:0] baud_divisor(input logic [2:0] sel);
    case (sel)
      3'd0:    return 14'd10417; // 300
      3'd1:    return 14'd2604;  // 1200
      3'd2:    return 14'd651;   // 4800
      3'd3:    return 14'd326;   // 9600
      3'd4:    return 14'd163;   // 19200
      3'd5:    return 14'd81;    // 38400
      3'd6:    return 14'd54;    // 57600
      default: return 14'd27;    // 115200
    endcase
  endfunction

endpackage

// File: rtl/baud_controller.sv
// Sample-enable generator: one-clk pulse at 16x the selected baud rate.
module baud_controller
  import uart_receiver_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud_select,
  output logic       sample_enable
);

  logic [BAUD_CNT_W-1:0] cnt;
  logic [BAUD_CNT_W-1:0] last;

  assign last = baud_divisor(baud_select) - 1'b1;

  // Free-running divider; ">=" keeps it bounded if baud_select shrinks.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      sample_enable <= 1'b0;
    end else if (cnt >= last) begin
      cnt           <= '0;
      sample_enable <= 1'b1;
    end else begin
      cnt           <= cnt + 1'b1;
      sample_enable <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_sync.sv
// RxD synchronizer into clk plus falling-edge detector on the synchronized line.
module uart_rx_sync
  import uart_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxs,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs_q;

  // Shift the raw line through the synchronizer; reset to the idle level so
  // reset release never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      rxs_q  <= IDLE_LEVEL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      rxs_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign fall = rxs_q & ~rxs;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits LSB first, even (XOR) parity, one stop bit,
// mid-bit sampling at OVERSAMPLE ticks per bit.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  rx_state_e state, state_nxt;

  logic       tick;
  logic       rxs;
  logic       fall;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       par_bit;

  // Decoded strobes for the datapath
  logic mid_start;
  logic full_bit;
  logic start_ok;
  logic bit_sample;
  logic par_sample;
  logic stop_sample;
  logic clr_tick;

  baud_controller u_baud (
    .clk           (clk),
    .rst           (rst),
    .baud_select   (baud_select),
    .sample_enable (tick)
  );

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .rxd  (RxD),
    .rxs  (rxs),
    .fall (fall)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a disabled receiver always drops back to idle
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    if (!Rx_EN) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (fall) state_nxt = ST_START;
        ST_START:  if (mid_start) state_nxt = rxs ? ST_IDLE : ST_DATA;
        ST_DATA:   if (full_bit && bit_cnt == BIT_LAST) state_nxt = ST_PARITY;
        ST_PARITY: if (full_bit) state_nxt = ST_STOP;
        ST_STOP:   if (full_bit) state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output/strobe decode from state, tick and counters
  always_comb begin
    mid_start   = tick && (tick_cnt == TICK_MID);
    full_bit    = tick && (tick_cnt == TICK_LAST);
    start_ok    = (state == ST_START)  && mid_start && !rxs;
    bit_sample  = (state == ST_DATA)   && full_bit;
    par_sample  = (state == ST_PARITY) && full_bit;
    stop_sample = (state == ST_STOP)   && full_bit;
    clr_tick    = ((state == ST_IDLE) && fall) || start_ok;
  end

  // Counters, shift register and frame result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      Rx_DATA   <= 8'h00;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else if (!Rx_EN) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      Rx_VALID <= 1'b0;
    end else begin
      Rx_VALID <= 1'b0;

      if (clr_tick)
        tick_cnt <= '0;
      else if (tick)
        tick_cnt <= (tick_cnt == TICK_LAST) ? 4'd0 : tick_cnt + 4'd1;

      if (start_ok) begin
        bit_cnt   <= '0;
        Rx_PERROR <= 1'b0;
        Rx_FERROR <= 1'b0;
      end

      if (bit_sample) begin
        shift   <= {rxs, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (par_sample)
        par_bit <= rxs;

      if (stop_sample) begin
        Rx_DATA   <= shift;
        Rx_PERROR <= par_bit ^ (^shift);
        Rx_FERROR <= ~rxs;
        Rx_VALID  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table of whole frames plus
// hand-written sequences for framing hold-low, glitches and interruptions.
module tb_uart_receiver;
  import uart_receiver_pkg::*;

  localparam logic [2:0] BAUD_SEL = 3'd7;     // 27 clk per tick
  localparam int         BIT_CLKS = 16 * 27;

  logic       clk = 1'b0;
  logic       rst;
  logic       RxD;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_count = 0;
  int long_pulse  = 0;
  logic valid_prev = 1'b0;

  uart_receiver #(
    .OVERSAMPLE  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .RxD         (RxD),
    .baud_select (baud_select),
    .Rx_EN       (Rx_EN),
    .Rx_DATA     (Rx_DATA),
    .Rx_VALID    (Rx_VALID),
    .Rx_PERROR   (Rx_PERROR),
    .Rx_FERROR   (Rx_FERROR)
  );

  always #5 clk = ~clk;

  // Count valid pulses and any pulse longer than one clk
  always @(negedge clk) begin
    if (Rx_VALID) valid_count++;
    if (Rx_VALID && valid_prev) long_pulse++;
    valid_prev = Rx_VALID;
  end

  // Watchdog: the whole run is about 60k clocks
  initial begin
    #(90_000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    RxD = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ par_flip);
    send_bit(stop);
  endtask

  task automatic expect_frame(input string name, input int exp_cnt, input logic [7:0] d,
                              input logic perr, input logic ferr);
    check({name, "_count"}, valid_count, exp_cnt);
    check({name, "_data"},  Rx_DATA, d);
    check({name, "_perr"},  Rx_PERROR, perr);
    check({name, "_ferr"},  Rx_FERROR, ferr);
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       par_flip;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int base;

    vecs[0] = '{"a5",   8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{"3c_p", 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{"b2b00", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{"b2bff", 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{"b2b81", 8'h81, 1'b0, 8'h81, 1'b0, 1'b0};

    rst = 1'b1;
    RxD = 1'b1;
    baud_select = BAUD_SEL;
    Rx_EN = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;

    check("rst_data",  Rx_DATA, 8'h00);
    check("rst_valid", Rx_VALID, 1'b0);
    check("rst_perr",  Rx_PERROR, 1'b0);
    check("rst_ferr",  Rx_FERROR, 1'b0);
    check("rst_state", 32'(dut.state), 32'(ST_IDLE));

    send_bit(1'b1);
    send_bit(1'b1);

    // Frames sent with no gap between them
    for (int i = 0; i < 5; i++) begin
      base = valid_count;
      send_frame(vecs[i].data, vecs[i].par_flip, 1'b1);
      expect_frame(vecs[i].name, base + 1, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
    end

    // Framing error with the line held low for 3 bit periods
    base = valid_count;
    send_frame(8'h55, 1'b0, 1'b0);
    expect_frame("ferr55", base + 1, 8'h55, 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    check("ferr_hold_count", valid_count, base + 1);
    check("ferr_hold_flag", Rx_FERROR, 1'b1);
    send_bit(1'b1);
    send_frame(8'h12, 1'b0, 1'b1);
    expect_frame("after_ferr12", base + 2, 8'h12, 1'b0, 1'b0);

    // Start glitch of 4 ticks
    base = valid_count;
    RxD = 1'b0;
    repeat (4 * 27) @(negedge clk);
    send_bit(1'b1);
    check("glitch_count", valid_count, base);
    check("glitch_state", 32'(dut.state), 32'(ST_IDLE));
    send_frame(8'hC3, 1'b0, 1'b1);
    expect_frame("after_glitch_c3", base + 1, 8'hC3, 1'b0, 1'b0);

    // Rx_EN dropped after bit 4 of 0xF0
    base = valid_count;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(bit'((8'hF0 >> i) & 8'h01));
    Rx_EN = 1'b0;
    RxD = 1'b1;
    repeat (2) @(negedge clk);
    check("en_off_state", 32'(dut.state), 32'(ST_IDLE));
    send_bit(1'b1);
    send_bit(1'b1);
    Rx_EN = 1'b1;
    send_bit(1'b1);
    check("en_off_count", valid_count, base);
    check("en_off_data_hold", Rx_DATA, 8'hC3);
    send_frame(8'h81, 1'b0, 1'b1);
    expect_frame("after_en_81", base + 1, 8'h81, 1'b0, 1'b0);

    // rst pulsed for one clk after bit 4 of 0xF0
    base = valid_count;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(bit'((8'hF0 >> i) & 8'h01));
    rst = 1'b1;
    RxD = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_data",  Rx_DATA, 8'h00);
    check("midrst_state", 32'(dut.state), 32'(ST_IDLE));
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("midrst_count", valid_count, base);
    send_frame(8'h81, 1'b0, 1'b1);
    expect_frame("after_rst_81", base + 1, 8'h81, 1'b0, 1'b0);

    check("valid_one_clk", long_pulse, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
